// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit with architectural HI/LO registers.
// Radix-2 Booth multiply and restoring divide, one iteration per clock.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int CW = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] mq;
    logic              q_1;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W:0]   dvsr;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W:0]   mext;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   acc_nx;
    logic [DATA_W-1:0] mq_nx;
    logic              q1_nx;
    logic [DATA_W+1:0] shifted;
    logic              fits;
    logic [DATA_W:0]   rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic              last_iter;

    // Booth step: acc is one bit wider than the operands so that
    // adding/subtracting -2^31 never overflows before the arithmetic shift.
    always_comb begin
        mext = {mcand[DATA_W-1], mcand};
        unique case ({mq[0], q_1})
            2'b01:   sum = acc + mext;
            2'b10:   sum = acc - mext;
            default: sum = acc;
        endcase
        acc_nx = {sum[DATA_W], sum[DATA_W:1]};
        mq_nx  = {sum[0], mq[DATA_W-1:1]};
        q1_nx  = mq[0];
    end

    // Restoring divide step on magnitudes.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        fits    = shifted >= {1'b0, dvsr};
        rem_nx  = fits ? (DATA_W+1)'(shifted - {1'b0, dvsr}) : (DATA_W+1)'(shifted);
        quo_nx  = {quo[DATA_W-2:0], fits};
    end

    assign last_iter = (count == CW'(DATA_W - 1));
    assign busy      = (state == S_MULT) || (state == S_DIV);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_zero <= 1'b0;
            acc      <= '0;
            mq       <= '0;
            q_1      <= 1'b0;
            mcand    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    count <= '0;
                    if (start_mult) begin
                        state    <= S_MULT;
                        div_zero <= 1'b0;
                        acc      <= '0;
                        mq       <= b_in;
                        q_1      <= 1'b0;
                        mcand    <= a_in;
                    end else if (start_div) begin
                        if (b_in == '0) begin
                            state    <= S_DONE;
                            div_zero <= 1'b1;
                        end else begin
                            state    <= S_DIV;
                            div_zero <= 1'b0;
                            rem      <= '0;
                            quo      <= DATA_W'(a_in[DATA_W-1] ? -{a_in[DATA_W-1], a_in}
                                                               : {a_in[DATA_W-1], a_in});
                            dvsr     <= b_in[DATA_W-1] ? -{b_in[DATA_W-1], b_in}
                                                       : {b_in[DATA_W-1], b_in};
                            neg_q    <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                            neg_r    <= a_in[DATA_W-1];
                        end
                    end
                end
                S_MULT: begin
                    acc   <= acc_nx;
                    mq    <= mq_nx;
                    q_1   <= q1_nx;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state  <= S_DONE;
                        hi_out <= acc_nx[DATA_W-1:0];
                        lo_out <= mq_nx;
                    end
                end
                S_DIV: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state  <= S_DONE;
                        hi_out <= neg_r ? -rem_nx[DATA_W-1:0] : rem_nx[DATA_W-1:0];
                        lo_out <= neg_q ? -quo_nx : quo_nx;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
